lsu_load_align: RTL and testbench
=================================

Name: lsu_load_align

Overview:
- Sequential load-data path between the LSU and data memory for the pipelined core.
- Takes a load request (byte address + load type) and issues one or two word-aligned memory reads through a valid/ready handshake.
- Stitches the returned words together, byte-shifts them by the address offset, then sign- or zero-extends the result to DATA_W.
- Generalises the single-cycle load extender: supports DATA_W of 32 or 64, splits misaligned accesses in hardware, and flags illegal types.

Parameters:
DATA_W, 32, datapath and memory word width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
SPLIT_EN, 1, 1 = misaligned loads are split into two reads; 0 = misaligned loads return an error.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_reset  input  1  asynchronous reset, active-high.
i_req_valid  input  1  load request valid.
o_req_ready  output  1  high only in IDLE.
i_req_addr  input  ADDR_W  byte address.
i_req_sl_sel  input  3  load type: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101 lwu, 110 ld.
o_mem_req  output  1  memory read valid.
i_mem_ready  input  1  memory accepts read.
o_mem_addr  output  ADDR_W  word-aligned read address; low log2(DATA_W/8) bits are 0.
i_mem_rvalid  input  1  read data valid.
i_mem_rdata  input  DATA_W  read data.
o_rsp_valid  output  1  result valid.
i_rsp_ready  input  1  consumer accepts result.
o_rsp_data  output  DATA_W  extended load data.
o_rsp_err  output  1  misaligned (with SPLIT_EN=0) or illegal type.

Behaviour:
- Reset: state IDLE; all outputs 0 except o_req_ready=1; captured words and request registers cleared.
- Reset mid-operation aborts the load. An i_mem_rvalid arriving after reset is ignored.
- Definitions:
  - NB = DATA_W/8.
  - off = addr mod NB.
  - size = 1/2/4/8 bytes for b/h/w/d types.
  - misaligned when off + size > NB.
- Illegal types:
  - 111 is illegal.
  - 110 is illegal when DATA_W=32.
  - 101 with DATA_W=32 behaves as lw.
- State machine (IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE):
  - IDLE: on i_req_valid, latch addr/type.
    - Illegal type, or misaligned with SPLIT_EN=0: go to DONE with err=1, data=0, no memory access.
    - Otherwise: go to REQ0.
  - REQ0: o_mem_req=1, o_mem_addr = addr with low bits cleared. On i_mem_ready go to WAIT0.
  - WAIT0: on i_mem_rvalid capture word0. Go to REQ1 if misaligned, else DONE.
  - REQ1: o_mem_req=1, o_mem_addr = aligned addr + NB (wraps modulo 2^ADDR_W). On i_mem_ready go to WAIT1.
  - WAIT1: on i_mem_rvalid capture word1, go to DONE.
  - DONE: o_rsp_valid=1. Data and err are stable while valid. On i_rsp_ready go to IDLE.
- Handshake rules:
  - o_mem_addr is held stable while o_mem_req=1 and i_mem_ready=0.
  - i_mem_rvalid is honoured no earlier than the cycle after the accept; it is ignored in any state other than WAIT0/WAIT1.
  - One outstanding read at a time.
- Assembly: raw = ({word1, word0} >> (8*off)) truncated to size bytes; word1 = 0 when not split.
  - Signed types replicate bit 8*size-1.
  - Unsigned types and ld zero-fill.
- Latency, zero-wait memory (i_mem_ready=1, rvalid the next cycle):
  - Aligned: request accept at cycle 0, o_rsp_valid at cycle 3.
  - Split: o_rsp_valid at cycle 5.
  - Error: o_rsp_valid at cycle 1.
- Back-pressure: with i_rsp_ready=0, DONE holds indefinitely and o_req_ready stays 0.
- No new request is accepted in the same cycle the response is accepted; the next accept is the following IDLE cycle.

Test Plan:
- DATA_W=32, lb at addr 0x103, memory word 0x80FF_1234 → o_mem_addr 0x100; o_rsp_data 0xFFFF_FF80, err 0, valid at cycle 3.
- lhu at 0x102, same word → 0x0000_80FF; lh → 0xFFFF_80FF.
- SPLIT_EN=1, lw at 0x0FE, words 0x1122_3344 @0x0FC and 0x5566_7788 @0x100 → two reads (0x0FC then 0x100); data 0x7788_1122, valid at cycle 5.
- SPLIT_EN=0, lh at 0x003 → no o_mem_req; err 1, data 0 at cycle 1. Type 111 at any address → same error response.
- DATA_W=64, ld at 0x10, word 0xDEAD_BEEF_0123_4567 → data unchanged. lwu at 0x14 → 0x0000_0000_DEAD_BEEF. lw at 0x14 → 0xFFFF_FFFF_DEAD_BEEF.
- Hold i_mem_ready=0 for 4 cycles then i_rsp_ready=0 for 3 cycles → address, data and valid stay stable throughout. Assert i_reset during WAIT0 → IDLE with outputs cleared; a later stray rvalid produces no response.

Source files
------------

// File: rtl/lsu_load_align.sv
// Load-data path between the LSU and data memory.
// Accepts a load request (byte address + load type), issues one or two
// word-aligned reads over a valid/ready handshake, stitches the returned
// words, shifts by the byte offset and sign/zero-extends to DATA_W.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready   load request handshake (ready only in IDLE)
//   i_req_addr, i_req_sl_sel  byte address, load type (lb/lh/lw/lbu/lhu/lwu/ld)
//   o_mem_req/i_mem_ready     memory read handshake, o_mem_addr word-aligned
//   i_mem_rvalid, i_mem_rdata read return
//   o_rsp_valid/i_rsp_ready   result handshake, o_rsp_data / o_rsp_err
module lsu_load_align #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SPLIT_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [2:0]        i_req_sl_sel,
  output logic              o_mem_req,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned SH_W  = OFF_W + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] word0_q, word0_d, word1_q, word1_d;

  logic [2:0]        cur_sel;
  logic [OFF_W-1:0]  cur_off;
  logic [3:0]        cur_size;
  logic              cur_signed, cur_illegal, cur_misal;

  logic [SH_W-1:0]   byte_sh;
  logic [3:0]        eff_size;
  logic [7:0]        pad;
  logic [DATA_W-1:0] raw, left, ext;
  logic signed [DATA_W-1:0] left_s;
  logic [ADDR_W-1:0] base_addr;

  logic              req_ready_d, mem_req_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] rsp_data_d;

  // Decode of the active request: live inputs while idle, latched copy afterwards
  always_comb begin
    cur_sel     = (state == IDLE) ? i_req_sl_sel : sel_q;
    cur_off     = (state == IDLE) ? i_req_addr[OFF_W-1:0] : addr_q[OFF_W-1:0];
    cur_size    = 4'd1;
    cur_signed  = 1'b0;
    cur_illegal = 1'b0;
    case (cur_sel)
      3'b000: begin cur_size = 4'd1; cur_signed = 1'b1; end
      3'b001: begin cur_size = 4'd2; cur_signed = 1'b1; end
      3'b010: begin cur_size = 4'd4; cur_signed = 1'b1; end
      3'b011: cur_size = 4'd1;
      3'b100: cur_size = 4'd2;
      // lwu on a 32-bit datapath fills the whole word, so it matches lw
      3'b101: cur_size = 4'd4;
      3'b110: begin cur_size = 4'd8; cur_illegal = (DATA_W == 32); end
      default: cur_illegal = 1'b1;
    endcase
    cur_misal = (4'(cur_off) + cur_size) > 4'(NB);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          if (cur_illegal || (cur_misal && (SPLIT_EN == 0))) state_d = DONE;
          else                                               state_d = REQ0;
        end
      end
      REQ0:  if (i_mem_ready)  state_d = WAIT0;
      WAIT0: if (i_mem_rvalid) state_d = cur_misal ? REQ1 : DONE;
      REQ1:  if (i_mem_ready)  state_d = WAIT1;
      WAIT1: if (i_mem_rvalid) state_d = DONE;
      DONE:  if (i_rsp_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and returned-word capture; word1 stays 0 for unsplit loads
  always_comb begin
    addr_d  = addr_q;
    sel_d   = sel_q;
    word0_d = word0_q;
    word1_d = word1_q;
    if (state == IDLE && i_req_valid) begin
      addr_d  = i_req_addr;
      sel_d   = i_req_sl_sel;
      word0_d = '0;
      word1_d = '0;
    end
    if (state == WAIT0 && i_mem_rvalid) word0_d = i_mem_rdata;
    if (state == WAIT1 && i_mem_rvalid) word1_d = i_mem_rdata;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_q  <= '0;
      sel_q   <= '0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
    end
  end

  // Assembly: shift the word pair down by the offset, then truncate/extend by
  // pushing the wanted bytes to the top and shifting back (arith for signed)
  always_comb begin
    byte_sh  = {cur_off, 3'b000};
    raw      = DATA_W'({word1_d, word0_d} >> byte_sh);
    eff_size = (cur_size > 4'(NB)) ? 4'(NB) : cur_size;
    pad      = 8'(DATA_W) - {1'b0, eff_size, 3'b000};
    left     = raw << pad;
    left_s   = left;
    ext      = cur_signed ? DATA_W'(left_s >>> pad) : (left >> pad);
  end

  assign base_addr = {addr_d[ADDR_W-1:OFF_W], OFF_W'(0)};

  // Output decode from the next state so every output comes straight off a flop
  always_comb begin
    req_ready_d = 1'b0;
    mem_req_d   = 1'b0;
    mem_addr_d  = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    case (state_d)
      IDLE: req_ready_d = 1'b1;
      REQ0: begin
        mem_req_d  = 1'b1;
        mem_addr_d = base_addr;
      end
      REQ1: begin
        mem_req_d  = 1'b1;
        mem_addr_d = base_addr + ADDR_W'(NB);
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        if (state == DONE) begin
          rsp_data_d = o_rsp_data;
          rsp_err_d  = o_rsp_err;
        end else if (state == IDLE) begin
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = ext;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_req_ready <= 1'b1;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_req_ready <= req_ready_d;
      o_mem_req   <= mem_req_d;
      o_mem_addr  <= mem_addr_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_data  <= rsp_data_d;
      o_rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_load_align.sv
// Bench for lsu_load_align: three instances (32-bit split, 32-bit no-split,
// 64-bit split) share a clock/reset and a word-addressed memory model.
module tb_lsu_load_align;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] data;
    logic        err;
    int          lat;
    int          nreq;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic [2:0]  req_sel   [3];
  logic        mem_ready [3];
  logic        mem_rvalid[3];
  logic        rsp_ready [3];
  logic        rv_en     [3];
  logic        stray     [3];
  logic        req_ready [3];
  logic        mem_req   [3];
  logic [31:0] mem_addr  [3];
  logic        rsp_valid [3];
  logic        rsp_err   [3];
  logic [31:0] rdat32    [2];
  logic [63:0] rdat64;
  logic [31:0] rd_s32, rd_n32;
  logic [63:0] rd_64;

  logic [63:0] memv [logic [31:0]];
  exp_t        sbq [$];
  vec_t        vt [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_load_align #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) u_s32 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(req_addr[0]), .i_req_sl_sel(req_sel[0]), .o_mem_req(mem_req[0]),
    .i_mem_ready(mem_ready[0]), .o_mem_addr(mem_addr[0]), .i_mem_rvalid(mem_rvalid[0]),
    .i_mem_rdata(rdat32[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_data(rd_s32), .o_rsp_err(rsp_err[0]));

  lsu_load_align #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) u_n32 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(req_addr[1]), .i_req_sl_sel(req_sel[1]), .o_mem_req(mem_req[1]),
    .i_mem_ready(mem_ready[1]), .o_mem_addr(mem_addr[1]), .i_mem_rvalid(mem_rvalid[1]),
    .i_mem_rdata(rdat32[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_data(rd_n32), .o_rsp_err(rsp_err[1]));

  lsu_load_align #(.DATA_W(64), .ADDR_W(32), .SPLIT_EN(1)) u_s64 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_addr(req_addr[2]), .i_req_sl_sel(req_sel[2]), .o_mem_req(mem_req[2]),
    .i_mem_ready(mem_ready[2]), .o_mem_addr(mem_addr[2]), .i_mem_rvalid(mem_rvalid[2]),
    .i_mem_rdata(rdat64), .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]),
    .o_rsp_data(rd_64), .o_rsp_err(rsp_err[2]));

  function automatic logic [63:0] memrd(input logic [31:0] a);
    if (memv.exists(a)) return memv[a];
    return {~a, a};
  endfunction

  function automatic logic [63:0] rdata_of(input int d);
    if (d == 0) return {32'h0, rd_s32};
    if (d == 1) return {32'h0, rd_n32};
    return rd_64;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: assemble the load byte by byte from the memory image
  task automatic model(input int d, input logic [31:0] a, input logic [2:0] sel,
                       output logic [63:0] data, output logic err, output int lat, output int nreq);
    int nb, size, off;
    bit sgn, ill, mis;
    logic [31:0] ba;
    logic [63:0] w;
    nb = (d == 2) ? 8 : 4;
    sgn = 0; ill = 0; size = 1;
    case (sel)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 1; end
      3'd3: size = 1;
      3'd4: size = 2;
      3'd5: size = 4;
      3'd6: begin size = 8; ill = (nb == 4); end
      default: ill = 1;
    endcase
    off = int'(a) % nb;
    mis = (off + size) > nb;
    data = 64'h0;
    if (ill || (mis && d == 1)) begin
      err = 1'b1; lat = 1; nreq = 0;
    end else begin
      err = 1'b0; lat = mis ? 5 : 3; nreq = mis ? 2 : 1;
      for (int i = 0; i < size; i++) begin
        ba = a + 32'(i);
        w = memrd(ba & ~32'(nb - 1));
        data[8*i +: 8] = w[8*(int'(ba) % nb) +: 8];
      end
      if (sgn && size < 8 && data[8*size-1]) data = data | ~((64'h1 << (8*size)) - 64'h1);
      if (nb == 4) data[63:32] = 32'h0;
    end
  endtask

  // Memory responder: an accept seen before an edge yields rvalid in the next cycle
  initial begin
    logic        acc [3];
    logic [63:0] dat [3];
    for (int d = 0; d < 3; d++) begin acc[d] = 1'b0; dat[d] = 64'h0; mem_rvalid[d] = 1'b0; end
    rdat32[0] = 32'h0; rdat32[1] = 32'h0; rdat64 = 64'h0;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        mem_rvalid[d] = (acc[d] && rv_en[d]) || stray[d];
        if (d == 2) rdat64 = acc[d] ? dat[d] : 64'h0;
        else        rdat32[d] = acc[d] ? dat[d][31:0] : 32'h0;
        acc[d] = mem_req[d] && mem_ready[d] && !rst;
        dat[d] = memrd(mem_addr[d]);
      end
    end
  end

  task automatic do_load(input string name, input int d, input logic [31:0] a, input logic [2:0] sel,
                         input logic [63:0] edata, input logic eerr, input int elat, input int enreq);
    int t0, nacc, nb;
    bit got;
    exp_t e;
    nb = (d == 2) ? 8 : 4;
    @(negedge clk);
    for (int k = 0; k < 10 && !req_ready[d]; k++) @(negedge clk);
    req_valid[d] = 1'b1; req_addr[d] = a; req_sel[d] = sel;
    t0 = cyc;
    sbq.push_back('{data: edata, err: eerr, lat: elat});
    @(negedge clk);
    req_valid[d] = 1'b0;
    nacc = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (mem_req[d] && mem_ready[d]) begin
        check({name, " mem_addr"}, {32'h0, mem_addr[d]},
              {32'h0, (a & ~32'(nb - 1)) + 32'(nacc * nb)});
        nacc++;
      end
      if (rsp_valid[d]) begin
        e = sbq.pop_front();
        check({name, " data"}, rdata_of(d), e.data);
        check({name, " err"}, {63'h0, rsp_err[d]}, {63'h0, e.err});
        check({name, " latency"}, 64'(cyc - t0), 64'(e.lat));
        got = 1;
      end else @(negedge clk);
    end
    if (!got) begin
      void'(sbq.pop_front());
      check({name, " response timeout"}, 64'h0, 64'h1);
    end
    check({name, " mem reads"}, 64'(nacc), 64'(enreq));
    @(negedge clk);
    check({name, " released"}, {62'h0, rsp_valid[d], req_ready[d]}, 64'h1);
  endtask

  initial begin
    logic [63:0] md;
    logic        me;
    int          ml, mn, d, nb;
    logic [31:0] a;
    logic [2:0]  s;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 0; req_addr[i] = 0; req_sel[i] = 0; mem_ready[i] = 1;
      rsp_ready[i] = 1; rv_en[i] = 1; stray[i] = 0;
    end
    vt[0]  = '{0, 32'h103, 3'd0, 64'h80FF1234, 64'h0, 64'hFFFFFF80, 1'b0, 3, 1};
    vt[1]  = '{0, 32'h102, 3'd4, 64'h80FF1234, 64'h0, 64'h000080FF, 1'b0, 3, 1};
    vt[2]  = '{0, 32'h102, 3'd1, 64'h80FF1234, 64'h0, 64'hFFFF80FF, 1'b0, 3, 1};
    vt[3]  = '{0, 32'h0FE, 3'd2, 64'h11223344, 64'h55667788, 64'h77881122, 1'b0, 5, 2};
    vt[4]  = '{1, 32'h003, 3'd1, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0};
    vt[5]  = '{1, 32'h100, 3'd7, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0};
    vt[6]  = '{0, 32'h101, 3'd7, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0};
    vt[7]  = '{0, 32'h000, 3'd6, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0};
    vt[8]  = '{2, 32'h010, 3'd6, 64'hDEADBEEF01234567, 64'h0, 64'hDEADBEEF01234567, 1'b0, 3, 1};
    vt[9]  = '{2, 32'h014, 3'd5, 64'hDEADBEEF01234567, 64'h0, 64'h00000000DEADBEEF, 1'b0, 3, 1};
    vt[10] = '{2, 32'h014, 3'd2, 64'hDEADBEEF01234567, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0, 3, 1};
    vt[11] = '{0, 32'h101, 3'd5, 64'h80FF1234, 64'hAABBCCDD, 64'hDD80FF12, 1'b0, 5, 2};
    vt[12] = '{2, 32'h00F, 3'd1, 64'h8877665544332211, 64'hF0, 64'hFFFFFFFFFFFFF088, 1'b0, 5, 2};
    vt[13] = '{1, 32'h102, 3'd1, 64'h80FF1234, 64'h0, 64'hFFFF80FF, 1'b0, 3, 1};
    vt[14] = '{0, 32'hFFFFFFFF, 3'd2, 64'hAABBCCDD, 64'h44332211, 64'h332211AA, 1'b0, 5, 2};
    vt[15] = '{2, 32'h017, 3'd3, 64'hDEADBEEF01234567, 64'h0, 64'h00000000000000DE, 1'b0, 3, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready/req/valid/err dut%0d", i),
            {60'h0, req_ready[i], mem_req[i], rsp_valid[i], rsp_err[i]}, 64'h8);
      check($sformatf("reset data dut%0d", i), rdata_of(i), 64'h0);
      check($sformatf("reset mem_addr dut%0d", i), {32'h0, mem_addr[i]}, 64'h0);
    end

    for (int i = 0; i < 16; i++) begin
      nb = (vt[i].d == 2) ? 8 : 4;
      memv[vt[i].addr & ~32'(nb - 1)] = vt[i].w0;
      memv[(vt[i].addr & ~32'(nb - 1)) + 32'(nb)] = vt[i].w1;
      do_load($sformatf("vec%0d", i), vt[i].d, vt[i].addr, vt[i].sel,
              vt[i].data, vt[i].err, vt[i].lat, vt[i].nreq);
    end

    // Memory stall then response back-pressure
    memv[32'h200] = 64'hCAFEF00D;
    mem_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h200; req_sel[0] = 3'd2;
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall req/addr c%0d", k), {31'h0, mem_req[0], mem_addr[0]}, {31'h0, 1'b1, 32'h200});
      @(negedge clk);
    end
    mem_ready[0] = 1'b1;
    rsp_ready[0] = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid[0]; k++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold valid/ready c%0d", k), {62'h0, rsp_valid[0], req_ready[0]}, 64'h2);
      check($sformatf("hold data c%0d", k), rdata_of(0), 64'hCAFEF00D);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("backpressure release", {62'h0, rsp_valid[0], req_ready[0]}, 64'h1);

    // Reset while waiting for read data, then a stray rvalid
    rv_en[0] = 1'b0;
    req_valid[0] = 1'b1; req_addr[0] = 32'h200; req_sel[0] = 3'd2;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("in WAIT0 before reset", {62'h0, mem_req[0], req_ready[0]}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rv_en[0] = 1'b1;
    check("after reset ready/req/valid/err", {60'h0, req_ready[0], mem_req[0], rsp_valid[0], rsp_err[0]}, 64'h8);
    check("after reset data", rdata_of(0), 64'h0);
    stray[0] = 1'b1;
    @(negedge clk);
    stray[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("stray rvalid ignored c%0d", k), {62'h0, rsp_valid[0], req_ready[0]}, 64'h1);
    end

    // Randomised loads against the byte-level model
    for (int a0 = 32'h300; a0 < 32'h350; a0 += 8) memv[32'(a0)] = {$urandom, $urandom};
    for (int a0 = 32'h304; a0 < 32'h350; a0 += 8) memv[32'(a0)] = {$urandom, $urandom};
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, 2));
      a = 32'h300 + 32'($urandom_range(0, 63));
      s = 3'($urandom_range(0, 7));
      model(d, a, s, md, me, ml, mn);
      do_load($sformatf("rnd%0d d%0d a%h t%0d", i, d, a, s), d, a, s, md, me, ml, mn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
